usb_txn_sched: RTL and testbench
================================

// Module: usb_txn_sched
// PURPOSE
//  Transaction scheduler above the USB receive path. Consumes per-packet completion events and sequences each
//  OUT transaction: token, data, handshake. On good new data it starts the encryptor, then requests an ACK.
//  On a bad packet or a busy encryptor it requests a NAK. Tracks the DATA0/DATA1 toggle and drops duplicates.
// PARAMETERS
//  TOKEN_PID  8'h96   PID accepted as OUT token
//  DATA0_PID  8'h3C   PID of DATA0 packet
//  DATA1_PID  8'hB4   PID of DATA1 packet
//  ACK_PID    8'h2D   PID driven on tx_pid for ACK
//  NAK_PID    8'h5A   PID driven on tx_pid for NAK
//  TIMEOUT    1000    clk cycles allowed in WAIT_DATA (only with USB_TIMEOUT_EN)
//  CNT_W      16      timeout counter width; must satisfy TIMEOUT < 2**CNT_W
// PORTS
//  clk          in   1   system clock
//  n_rst        in   1   asynchronous reset, active-low
//  pkt_valid    in   1   1-cycle pulse: receiver finished a packet (EOP seen)
//  pkt_pid      in   8   PID of the finished packet; valid with pkt_valid
//  pkt_err      in   1   sync/PID/CRC error on the finished packet; valid with pkt_valid
//  enc_busy     in   1   encryptor is still processing the previous block
//  enc_done     in   1   1-cycle pulse: encryptor accepted the current block
//  enc_start    out  1   1-cycle pulse: hand the received 64-bit data block to the encryptor
//  tx_req       out  1   request handshake transmission; held high until tx_ack
//  tx_pid       out  8   handshake PID; stable while tx_req is high
//  tx_ack       in   1   1-cycle pulse: transmitter latched tx_pid
//  data_toggle  out  1   expected data toggle (0 = DATA0 next)
//  txn_busy     out  1   high in any state except IDLE
//  err_pulse    out  1   1-cycle pulse on protocol error or timeout
// BEHAVIOUR
//  Reset values: all outputs 0, tx_pid 8'h00, data_toggle 0, state IDLE, timeout counter 0.
//  All outputs are registered. n_rst mid-transaction aborts: tx_req drops at once and data_toggle returns to 0.
//  States: IDLE, WAIT_DATA, ENCRYPT, SEND_ACK, SEND_NAK.
//  IDLE: pkt_valid & !pkt_err & pid==TOKEN_PID -> WAIT_DATA. Any other pkt_valid -> err_pulse, stay IDLE.
//  WAIT_DATA: counter increments each cycle; it clears on entry. On pkt_valid:
//   - pkt_err, or pid not DATA0/DATA1 -> err_pulse, go to SEND_NAK.
//   - toggle bit of pid != data_toggle -> duplicate: go to SEND_ACK, no enc_start, toggle unchanged.
//   - toggle matches and enc_busy=1 -> go to SEND_NAK, toggle unchanged.
//   - toggle matches and enc_busy=0 -> enc_start pulses in the cycle the state becomes ENCRYPT.
//  ENCRYPT: wait for enc_done, then flip data_toggle and go to SEND_ACK. A pkt_valid here raises err_pulse
//   and is otherwise ignored.
//  SEND_ACK/SEND_NAK: tx_req=1 and tx_pid=ACK_PID/NAK_PID from the first cycle in the state. On tx_ack the
//   next cycle has tx_req=0 and state IDLE. A tx_ack while tx_req=0 is ignored. pkt_valid here is ignored.
//  Latency: token pkt_valid -> txn_busy high 1 cycle later. Data pkt_valid -> enc_start 1 cycle later.
//  enc_done -> tx_req 1 cycle later.
//  Simultaneous pkt_valid and enc_done in ENCRYPT: enc_done wins; the packet is flagged by err_pulse.
//  The counter saturates at its maximum and never wraps.
// CONFIGURATION
//  USB_TIMEOUT_EN defined:
//   - WAIT_DATA with counter == TIMEOUT-1 and no pkt_valid -> err_pulse, go to IDLE, no handshake.
//   - pkt_valid in that same cycle takes priority over the timeout.
//  USB_TIMEOUT_EN undefined:
//   - WAIT_DATA waits indefinitely; the counter is not instantiated.
//   - TIMEOUT and CNT_W are unused.
// TESTING
//  1 Token 8'h96, then DATA0 8'h3C with enc_busy=0 -> enc_start 1 cycle later.
//    enc_done -> tx_req with tx_pid 8'h2D; tx_ack -> IDLE, data_toggle=1.
//  2 Repeat DATA0 with data_toggle=1 -> no enc_start, ACK 8'h2D sent, data_toggle stays 1.
//  3 Token, then data with pkt_err=1 -> err_pulse, then tx_pid 8'h5A. Token, then DATA with enc_busy=1
//    -> NAK 8'h5A, no enc_start.
//  4 USB_TIMEOUT_EN with TIMEOUT=1000: token then silence -> err_pulse exactly 1000 cycles after WAIT_DATA
//    entry, IDLE, tx_req never asserted.
//  5 Drop n_rst during SEND_ACK with tx_req=1 -> tx_req=0 immediately, state IDLE, data_toggle=0.
//  6 In IDLE, pkt_valid with pid 8'h3C -> err_pulse, txn_busy stays 0.

Source files
------------

// File: rtl/usb_txn_sched.sv
// usb_txn_sched: OUT-transaction scheduler above the USB receive path.
// Sequences token -> data -> handshake, tracks the DATA0/DATA1 toggle,
// starts the encryptor on good new data and requests ACK/NAK handshakes.
// Optional feature macro: USB_TIMEOUT_EN (WAIT_DATA timeout with a
// saturating cycle counter). Without it WAIT_DATA waits indefinitely.
module usb_txn_sched #(
    parameter logic [7:0] TOKEN_PID = 8'h96,
    parameter logic [7:0] DATA0_PID = 8'h3C,
    parameter logic [7:0] DATA1_PID = 8'hB4,
    parameter logic [7:0] ACK_PID   = 8'h2D,
    parameter logic [7:0] NAK_PID   = 8'h5A,
    parameter int         TIMEOUT   = 1000,
    parameter int         CNT_W     = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       pkt_valid,
    input  logic [7:0] pkt_pid,
    input  logic       pkt_err,
    input  logic       enc_busy,
    input  logic       enc_done,
    output logic       enc_start,
    output logic       tx_req,
    output logic [7:0] tx_pid,
    input  logic       tx_ack,
    output logic       data_toggle,
    output logic       txn_busy,
    output logic       err_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_ENCRYPT   = 3'd2,
        ST_SEND_ACK  = 3'd3,
        ST_SEND_NAK  = 3'd4
    } state_t;

    // The timeout counter must be able to hold TIMEOUT-1.
    if ((TIMEOUT < 1) || (TIMEOUT >= (1 << CNT_W))) begin : g_bad_timeout_cfg
        $error("usb_txn_sched: TIMEOUT must be in 1 .. 2**CNT_W-1");
    end

    // True for either data PID.
    function automatic logic pid_is_data(input logic [7:0] pid);
        return (pid == DATA0_PID) || (pid == DATA1_PID);
    endfunction

    // Toggle bit carried by a data PID (1 = DATA1).
    function automatic logic pid_toggle(input logic [7:0] pid);
        return (pid == DATA1_PID);
    endfunction

    state_t     state_q, state_d;
    logic       data_toggle_q, data_toggle_d;
    logic       enc_start_q, enc_start_d;
    logic       tx_req_q, tx_req_d;
    logic [7:0] tx_pid_q, tx_pid_d;
    logic       txn_busy_q, txn_busy_d;
    logic       err_pulse_q, err_pulse_d;

`ifdef USB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Timeout counter: zero outside WAIT_DATA so it is clear on entry; saturates.
    always_comb begin
        cnt_d = {CNT_W{1'b0}};
        if (state_q == ST_WAIT_DATA) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next-state logic plus the registered-output next values.
    always_comb begin
        state_d       = state_q;
        data_toggle_d = data_toggle_q;
        enc_start_d   = 1'b0;
        err_pulse_d   = 1'b0;
        tx_req_d      = 1'b0;
        tx_pid_d      = 8'h00;
        txn_busy_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pkt_valid) begin
                    if (!pkt_err && (pkt_pid == TOKEN_PID)) begin
                        state_d = ST_WAIT_DATA;
                    end else begin
                        err_pulse_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (pkt_valid) begin
                    if (pkt_err || !pid_is_data(pkt_pid)) begin
                        err_pulse_d = 1'b1;
                        state_d     = ST_SEND_NAK;
                    end else if (pid_toggle(pkt_pid) != data_toggle_q) begin
                        // Retransmission of data already accepted: re-ACK only.
                        state_d = ST_SEND_ACK;
                    end else if (enc_busy) begin
                        state_d = ST_SEND_NAK;
                    end else begin
                        state_d     = ST_ENCRYPT;
                        enc_start_d = 1'b1;
                    end
                end else begin
`ifdef USB_TIMEOUT_EN
                    if (cnt_q == CNT_LAST) begin
                        err_pulse_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
`else
                    state_d = ST_WAIT_DATA;
`endif
                end
            end
            ST_ENCRYPT: begin
                // Any packet here is a protocol error; enc_done still proceeds.
                err_pulse_d = pkt_valid;
                if (enc_done) begin
                    data_toggle_d = ~data_toggle_q;
                    state_d       = ST_SEND_ACK;
                end else begin
                    state_d = ST_ENCRYPT;
                end
            end
            ST_SEND_ACK, ST_SEND_NAK: begin
                if (tx_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are valid in its first cycle.
        case (state_d)
            ST_SEND_ACK: begin
                tx_req_d = 1'b1;
                tx_pid_d = ACK_PID;
            end
            ST_SEND_NAK: begin
                tx_req_d = 1'b1;
                tx_pid_d = NAK_PID;
            end
            default: begin
                tx_req_d = 1'b0;
                tx_pid_d = 8'h00;
            end
        endcase
        txn_busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            data_toggle_q <= 1'b0;
            enc_start_q   <= 1'b0;
            tx_req_q      <= 1'b0;
            tx_pid_q      <= 8'h00;
            txn_busy_q    <= 1'b0;
            err_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_toggle_q <= data_toggle_d;
            enc_start_q   <= enc_start_d;
            tx_req_q      <= tx_req_d;
            tx_pid_q      <= tx_pid_d;
            txn_busy_q    <= txn_busy_d;
            err_pulse_q   <= err_pulse_d;
        end
    end

    assign enc_start   = enc_start_q;
    assign tx_req      = tx_req_q;
    assign tx_pid      = tx_pid_q;
    assign data_toggle = data_toggle_q;
    assign txn_busy    = txn_busy_q;
    assign err_pulse   = err_pulse_q;

endmodule

// File: tb/tb_usb_txn_sched.sv
// Directed self-checking bench for usb_txn_sched.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_usb_txn_sched;

    logic       clk;
    logic       n_rst;
    logic       pkt_valid;
    logic [7:0] pkt_pid;
    logic       pkt_err;
    logic       enc_busy;
    logic       enc_done;
    logic       enc_start;
    logic       tx_req;
    logic [7:0] tx_pid;
    logic       tx_ack;
    logic       data_toggle;
    logic       txn_busy;
    logic       err_pulse;

    int n_tests;
    int n_fail;

    usb_txn_sched dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .pkt_valid   (pkt_valid),
        .pkt_pid     (pkt_pid),
        .pkt_err     (pkt_err),
        .enc_busy    (enc_busy),
        .enc_done    (enc_done),
        .enc_start   (enc_start),
        .tx_req      (tx_req),
        .tx_pid      (tx_pid),
        .tx_ack      (tx_ack),
        .data_toggle (data_toggle),
        .txn_busy    (txn_busy),
        .err_pulse   (err_pulse)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle packet completion event.
    task automatic send_pkt(input logic [7:0] pid, input logic err);
        pkt_valid = 1'b1;
        pkt_pid   = pid;
        pkt_err   = err;
        tick();
        pkt_valid = 1'b0;
        pkt_err   = 1'b0;
        pkt_pid   = 8'h00;
    endtask

    // One-cycle transmitter acknowledge; handshake must then be gone.
    task automatic ack_hs(input string tag);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk({tag, "_req_drop"}, {31'd0, tx_req}, 32'd0);
        chk({tag, "_idle"}, {31'd0, txn_busy}, 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  saw_req;
        bit  saw_err;

        n_tests   = 0;
        n_fail    = 0;
        n_rst     = 1'b0;
        pkt_valid = 1'b0;
        pkt_pid   = 8'h00;
        pkt_err   = 1'b0;
        enc_busy  = 1'b0;
        enc_done  = 1'b0;
        tx_ack    = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
        chk("rst_tx_pid", {24'd0, tx_pid}, 32'h00);
        chk("rst_toggle", {31'd0, data_toggle}, 32'd0);
        chk("rst_busy", {31'd0, txn_busy}, 32'd0);
        chk("rst_enc_start", {31'd0, enc_start}, 32'd0);
        chk("rst_err", {31'd0, err_pulse}, 32'd0);
        n_rst = 1'b1;
        tick();

        // 1: good DATA0 path.
        send_pkt(8'h96, 1'b0);
        chk("t1_busy", {31'd0, txn_busy}, 32'd1);
        send_pkt(8'h3C, 1'b0);
        chk("t1_enc_start", {31'd0, enc_start}, 32'd1);
        tick();
        chk("t1_enc_start_pulse", {31'd0, enc_start}, 32'd0);
        chk("t1_no_req_yet", {31'd0, tx_req}, 32'd0);
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        chk("t1_tx_req", {31'd0, tx_req}, 32'd1);
        chk("t1_tx_pid", {24'd0, tx_pid}, 32'h2D);
        tick();
        chk("t1_req_held", {31'd0, tx_req}, 32'd1);
        ack_hs("t1");
        chk("t1_toggle", {31'd0, data_toggle}, 32'd1);

        // 2: duplicate DATA0 while DATA1 expected.
        send_pkt(8'h96, 1'b0);
        send_pkt(8'h3C, 1'b0);
        chk("t2_no_enc_start", {31'd0, enc_start}, 32'd0);
        chk("t2_tx_req", {31'd0, tx_req}, 32'd1);
        chk("t2_tx_pid", {24'd0, tx_pid}, 32'h2D);
        ack_hs("t2");
        chk("t2_toggle", {31'd0, data_toggle}, 32'd1);

        // 3a: corrupted data packet.
        send_pkt(8'h96, 1'b0);
        send_pkt(8'hB4, 1'b1);
        chk("t3_err", {31'd0, err_pulse}, 32'd1);
        chk("t3_nak_req", {31'd0, tx_req}, 32'd1);
        chk("t3_nak_pid", {24'd0, tx_pid}, 32'h5A);
        tick();
        chk("t3_err_pulse_len", {31'd0, err_pulse}, 32'd0);
        ack_hs("t3a");

        // 3b: encryptor busy.
        send_pkt(8'h96, 1'b0);
        enc_busy = 1'b1;
        send_pkt(8'hB4, 1'b0);
        enc_busy = 1'b0;
        chk("t3b_no_enc_start", {31'd0, enc_start}, 32'd0);
        chk("t3b_nak_pid", {24'd0, tx_pid}, 32'h5A);
        chk("t3b_no_err", {31'd0, err_pulse}, 32'd0);
        ack_hs("t3b");
        chk("t3b_toggle", {31'd0, data_toggle}, 32'd1);

        // Packet and enc_done together in ENCRYPT: done wins, packet flagged.
        send_pkt(8'h96, 1'b0);
        send_pkt(8'hB4, 1'b0);
        chk("enc_start_d1", {31'd0, enc_start}, 32'd1);
        enc_done = 1'b1;
        send_pkt(8'h3C, 1'b0);
        enc_done = 1'b0;
        chk("coll_err", {31'd0, err_pulse}, 32'd1);
        chk("coll_ack_pid", {24'd0, tx_pid}, 32'h2D);
        chk("coll_toggle", {31'd0, data_toggle}, 32'd0);
        ack_hs("coll");

        // 6: data PID in IDLE is an error and does not start a transaction.
        send_pkt(8'h3C, 1'b0);
        chk("t6_err", {31'd0, err_pulse}, 32'd1);
        chk("t6_busy", {31'd0, txn_busy}, 32'd0);

        // Stray tx_ack while idle is ignored.
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk("stray_ack_req", {31'd0, tx_req}, 32'd0);
        chk("stray_ack_busy", {31'd0, txn_busy}, 32'd0);

        // 4: WAIT_DATA with no data.
        send_pkt(8'h96, 1'b0);
        saw_req = 1'b0;
        saw_err = 1'b0;
        cyc     = 0;
`ifdef USB_TIMEOUT_EN
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (tx_req) saw_req = 1'b1;
            if (err_pulse) begin
                saw_err = 1'b1;
                cyc     = i;
                break;
            end
        end
        chk("t4_timeout_seen", {31'd0, saw_err}, 32'd1);
        chk("t4_timeout_cycles", cyc, 32'd1000);
        chk("t4_no_req", {31'd0, saw_req}, 32'd0);
        chk("t4_idle", {31'd0, txn_busy}, 32'd0);
`else
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (tx_req) saw_req = 1'b1;
            if (err_pulse) saw_err = 1'b1;
            cyc = i;
        end
        chk("t4_wait_cycles", cyc, 32'd1100);
        chk("t4_no_timeout", {31'd0, saw_err}, 32'd0);
        chk("t4_no_req", {31'd0, saw_req}, 32'd0);
        chk("t4_still_busy", {31'd0, txn_busy}, 32'd1);
        send_pkt(8'h00, 1'b0);
        chk("t4_bad_pid_err", {31'd0, err_pulse}, 32'd1);
        chk("t4_bad_pid_nak", {24'd0, tx_pid}, 32'h5A);
        ack_hs("t4");
`endif

        // 5: reset during SEND_ACK.
        send_pkt(8'h96, 1'b0);
        send_pkt(8'h3C, 1'b0);
        chk("t5_enc_start", {31'd0, enc_start}, 32'd1);
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        chk("t5_req_before", {31'd0, tx_req}, 32'd1);
        chk("t5_toggle_before", {31'd0, data_toggle}, 32'd1);
        #1;
        n_rst = 1'b0;
        #1;
        chk("t5_req_async", {31'd0, tx_req}, 32'd0);
        chk("t5_toggle_async", {31'd0, data_toggle}, 32'd0);
        chk("t5_busy_async", {31'd0, txn_busy}, 32'd0);
        #1;
        n_rst = 1'b1;
        tick();
        chk("t5_idle_after", {31'd0, txn_busy}, 32'd0);
        send_pkt(8'h3C, 1'b0);
        chk("t5_idle_data_err", {31'd0, err_pulse}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
